// File: rtl/sys_arr_pkg.sv
// Shared constants for the systolic-array feeder: lane byte width, buffer read
// latency and the feeder FSM state encodings.
package sys_arr_pkg;

  localparam int unsigned ByteW   = 8;
  localparam int unsigned ReadLat = 1;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StFetch = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

endpackage

// File: rtl/sys_arr_feeder_lane_delay.sv
// Zero-initialised shift register delaying one array lane by `depth` cycles.
module lane_delay
  import sys_arr_pkg::*;
#(
  parameter int unsigned depth = 1,
  parameter int unsigned width = ByteW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] sr_q [depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < depth; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q[0] <= d;
      for (int unsigned i = 1; i < depth; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q = sr_q[depth-1];

endmodule

// File: rtl/sys_arr_feeder.sv
// Fetches a batch of vectors from the unified buffer and feeds them to the
// systolic array with lane i skewed by i cycles.
module sys_arr_feeder
  import sys_arr_pkg::*;
#(
  parameter int unsigned width_height = 16,
  parameter int unsigned addr_width   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [addr_width-1:0]         base_addr,
  input  logic [addr_width-1:0]         num_vectors,
  output logic                          rd_en,
  output logic [addr_width-1:0]         rd_addr,
  input  logic [ByteW*width_height-1:0] rd_data,
  output logic [ByteW*width_height-1:0] datain,
  output logic                          active,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned DrainW = $clog2(width_height + 1);
  localparam logic [DrainW-1:0]     DrainLast = DrainW'(width_height);
  localparam logic [DrainW-1:0]     DrainOne  = DrainW'(1);
  localparam logic [addr_width-1:0] AddrOne   = addr_width'(1);

  state_t                  state_q, state_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic [addr_width-1:0]   cnt_q, cnt_d;
  logic [DrainW-1:0]       drain_q, drain_d;
  logic [ReadLat-1:0]      vld_q;
  logic                    rd_en_q, active_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_vectors == '0) begin
            state_d = StDone;
          end else begin
            addr_d  = base_addr;
            cnt_d   = num_vectors;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        addr_d = addr_q + AddrOne;
        cnt_d  = cnt_q - AddrOne;
        if (cnt_q == AddrOne) begin
          drain_d = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Wait until the deepest lane has shifted out the final vector.
        if (drain_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + DrainOne;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      cnt_q    <= '0;
      drain_q  <= '0;
      vld_q    <= '0;
      rd_en_q  <= 1'b0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      // Tracks which cycles carry a genuine buffer word on rd_data.
      vld_q    <= ReadLat'({vld_q, rd_en_q});
      active_q <= vld_q[ReadLat-1];
      rd_en_q  <= (state_d == StFetch);
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StDone);
    end
  end

  for (genvar i = 0; i < width_height; i++) begin : g_lane
    logic [ByteW-1:0] lane_in;

    // Invalid cycles inject zeros so no stale buffer data leaks into the array.
    assign lane_in = vld_q[ReadLat-1] ? rd_data[ByteW*i +: ByteW] : '0;

    lane_delay #(
      .depth(i + 1),
      .width(ByteW)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .d    (lane_in),
      .q    (datain[ByteW*i +: ByteW])
    );
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = addr_q;
  assign active  = active_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sys_arr_feeder.sv
// Directed bench for sys_arr_feeder at W=2 and W=4 with a cycle-stamped scoreboard.
module tb_sys_arr_feeder;

  typedef struct {
    int          cyc;
    logic [31:0] datain;
    logic        active;
    logic        done;
    logic        busy;
    logic        rd_en;
    logic [7:0]  rd_addr;
  } rec_t;

  logic        clk;
  logic        reset;
  logic        start2, start4;
  logic [7:0]  base2, num2, base4, num4;
  logic        rd_en2, rd_en4;
  logic [7:0]  rd_addr2, rd_addr4;
  logic [15:0] rd_data2, datain2;
  logic [31:0] rd_data4, datain4;
  logic        active2, busy2, done2;
  logic        active4, busy4, done4;

  logic [31:0] mem [256];
  logic [31:0] tp1 [4];
  rec_t        q2[$];
  rec_t        q4[$];
  int          cyc;
  int          checks;
  int          errors;
  int          done_cnt4;
  int          c0;

  sys_arr_feeder #(.width_height(2), .addr_width(8)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .start      (start2),
    .base_addr  (base2),
    .num_vectors(num2),
    .rd_en      (rd_en2),
    .rd_addr    (rd_addr2),
    .rd_data    (rd_data2),
    .datain     (datain2),
    .active     (active2),
    .busy       (busy2),
    .done       (done2)
  );

  sys_arr_feeder #(.width_height(4), .addr_width(8)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .start      (start4),
    .base_addr  (base4),
    .num_vectors(num4),
    .rd_en      (rd_en4),
    .rd_addr    (rd_addr4),
    .rd_data    (rd_data4),
    .datain     (datain4),
    .active     (active4),
    .busy       (busy4),
    .done       (done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: one-cycle read latency, garbage whenever no read was issued.
  always @(posedge clk) begin
    rd_data2 <= rd_en2 ? mem[rd_addr2][15:0] : 16'($urandom);
    rd_data4 <= rd_en4 ? mem[rd_addr4] : $urandom;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs for relative cycles 1..end of a batch started in cycle c.
  task automatic push_batch(input int w, input logic [7:0] base, input int n, input int c);
    rec_t        e;
    int          last;
    int          k;
    logic [31:0] word;
    last = (n == 0) ? 1 : n + w + 2;
    for (int r = 1; r <= last; r++) begin
      e.cyc     = c + r;
      e.rd_en   = (r <= n);
      e.rd_addr = base + 8'(r - 1);
      e.active  = (r >= 3) && (r <= n + 2);
      e.busy    = 1'b1;
      e.done    = (r == last);
      e.datain  = '0;
      for (int i = 0; i < w; i++) begin
        k = r - 3 - i;
        if (k >= 0 && k < n) begin
          word = mem[base + 8'(k)];
          e.datain[8*i +: 8] = word[8*i +: 8];
        end
      end
      if (w == 2) q2.push_back(e);
      else q4.push_back(e);
    end
  endtask

  task automatic check_dut(input int w, input logic [31:0] dat, input logic act,
                           input logic dn, input logic bsy, input logic re,
                           input logic [7:0] ra);
    rec_t  e;
    string p;
    e.cyc = cyc; e.datain = '0; e.active = 1'b0; e.done = 1'b0;
    e.busy = 1'b0; e.rd_en = 1'b0; e.rd_addr = '0;
    p = (w == 2) ? "w2" : "w4";
    if (w == 2) begin
      if (q2.size() > 0 && q2[0].cyc == cyc) e = q2.pop_front();
    end else begin
      if (q4.size() > 0 && q4[0].cyc == cyc) e = q4.pop_front();
    end
    chk({p, "_datain"}, dat, e.datain);
    chk({p, "_active"}, 32'(act), 32'(e.active));
    chk({p, "_done"}, 32'(dn), 32'(e.done));
    chk({p, "_busy"}, 32'(bsy), 32'(e.busy));
    chk({p, "_rd_en"}, 32'(re), 32'(e.rd_en));
    if (e.rd_en) chk({p, "_rd_addr"}, 32'(ra), 32'(e.rd_addr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_dut(2, 32'(datain2), active2, done2, busy2, rd_en2, rd_addr2);
    check_dut(4, datain4, active4, done4, busy4, rd_en4, rd_addr4);
    if (done4 === 1'b1) done_cnt4++;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; done_cnt4 = 0;
    for (int a = 0; a < 256; a++) mem[a] = $urandom | 32'h01010101;
    mem[0] = 32'h0A0B0201;
    mem[1] = 32'h0C0D0403;
    mem[2] = 32'h0E0F0605;
    tp1[0] = 32'h0001; tp1[1] = 32'h0203; tp1[2] = 32'h0405; tp1[3] = 32'h0600;
    reset = 1'b1;
    start2 = 1'b0; base2 = '0; num2 = '0;
    start4 = 1'b0; base4 = '0; num4 = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_datain4", datain4, 32'h0);
    chk("rst_datain2", 32'(datain2), 32'h0);
    chk("rst_outs4", {28'h0, rd_en4, active4, busy4, done4}, 32'h0);
    chk("rst_rd_addr4", 32'(rd_addr4), 32'h0);
    reset = 1'b0;
    tick();

    // W=2 base 0 N=3 with literal datain, rd_addr and done timing.
    c0 = cyc;
    start2 = 1'b1; base2 = 8'h00; num2 = 8'd3;
    push_batch(2, 8'h00, 3, c0);
    for (int r = 1; r <= 7; r++) begin
      tick();
      if (r == 1) begin start2 = 1'b0; base2 = 8'h55; num2 = 8'd9; end
      if (r <= 3) chk("tp1_rd_addr", 32'(rd_addr2), 32'(r - 1));
      if (r >= 3 && r <= 6) chk("tp1_datain", 32'(datain2), tp1[r-3]);
      chk("tp1_done", 32'(done2), 32'(r == 7));
    end
    repeat (2) tick();

    // W=4 address wrap.
    c0 = cyc;
    start4 = 1'b1; base4 = 8'hFE; num4 = 8'd4;
    push_batch(4, 8'hFE, 4, c0);
    tick();
    start4 = 1'b0;
    repeat (5) tick();
    chk("wrap_lane3_v0", 32'(datain4[31:24]), 32'(mem[8'hFE][31:24]));
    repeat (4) tick();
    chk("wrap_done_c10", 32'(done4), 32'h1);
    repeat (2) tick();

    // Empty batch.
    start4 = 1'b1; base4 = 8'h10; num4 = 8'd0;
    push_batch(4, 8'h10, 0, cyc);
    tick();
    start4 = 1'b0;
    chk("n0_done", 32'(done4), 32'h1);
    chk("n0_busy", 32'(busy4), 32'h1);
    tick();
    chk("n0_busy_end", 32'(busy4), 32'h0);
    repeat (2) tick();

    // start during FETCH and DRAIN ignored; restart right after done.
    done_cnt4 = 0;
    start4 = 1'b1; base4 = 8'h08; num4 = 8'd3;
    push_batch(4, 8'h08, 3, cyc);
    tick(); start4 = 1'b0;
    tick(); start4 = 1'b1; base4 = 8'h40; num4 = 8'd7;
    tick(); start4 = 1'b0;
    tick(); start4 = 1'b1;
    tick(); start4 = 1'b0;
    repeat (4) tick();
    tick();
    chk("ign_one_done", 32'(done_cnt4), 32'd1);
    start4 = 1'b1; base4 = 8'h20; num4 = 8'd2;
    push_batch(4, 8'h20, 2, cyc);
    tick();
    start4 = 1'b0;
    repeat (7) tick();
    chk("ign_second_done", 32'(done_cnt4), 32'd2);
    repeat (2) tick();

    // Reset in cycle N+1 of a W=4 N=5 batch.
    start4 = 1'b1; base4 = 8'h80; num4 = 8'd5;
    push_batch(4, 8'h80, 5, cyc);
    tick();
    start4 = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    q2.delete();
    q4.delete();
    tick();
    chk("rst_mid_rd_addr", 32'(rd_addr4), 32'h0);
    chk("rst_mid_datain", datain4, 32'h0);
    reset = 1'b0;
    start4 = 1'b1; base4 = 8'h90; num4 = 8'd2;
    push_batch(4, 8'h90, 2, cyc);
    tick();
    start4 = 1'b0;
    repeat (9) tick();

    // W=2 N=1 then N=2 back to back.
    start2 = 1'b1; base2 = 8'h10; num2 = 8'd1;
    push_batch(2, 8'h10, 1, cyc);
    tick();
    start2 = 1'b0;
    repeat (4) tick();
    tick();
    start2 = 1'b1; base2 = 8'h30; num2 = 8'd2;
    push_batch(2, 8'h30, 2, cyc);
    tick();
    start2 = 1'b0;
    repeat (8) tick();

    chk("sb_empty2", 32'(q2.size()), 32'd0);
    chk("sb_empty4", 32'(q4.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_arr_feeder.md
# sys_arr_feeder

Upstream stage of the systolic array: fetches input vectors from the unified buffer and presents them on the array's `datain`/`active` inputs. Lane i (row i) is delayed by i cycles, forming the diagonal wavefront the array needs. A single `start` runs one batch of `num_vectors` consecutive buffer words. `done` pulses once the last skewed byte has entered the array.

## Interface
- `width_height`, 16: array rows/columns; number of 8-bit lanes.
- `addr_width`, 8: buffer address width; also the width of the vector count.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `base_addr` in addr_width: address of the first vector; sampled with `start`.
- `num_vectors` in addr_width: vector count; sampled with `start`; 0 is legal.
- `rd_en` out 1: buffer read strobe.
- `rd_addr` out addr_width: buffer read address.
- `rd_data` in 8*width_height: buffer word, valid exactly 1 cycle after `rd_en`; byte i → lane i.
- `datain` out 8*width_height: skewed data to the array; bits [8i+7:8i] = row i.
- `active` out 1: high while lane 0 carries a valid vector.
- `busy` out 1: batch in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- All outputs are registered. Reset value of every output is 0, including all delay-line contents.
- FSM states:
  - IDLE: `start`=1 and `num_vectors`>0 → FETCH. `start`=1 and `num_vectors`=0 → DONE, with no reads issued.
  - FETCH: `rd_en`=1 for exactly N cycles, with `rd_addr` = base, base+1, … base+N-1. Addresses wrap mod 2^addr_width. After the N-th read → DRAIN.
  - DRAIN: counts until lane width_height-1 has output the last vector → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `busy` = 1 in FETCH, DRAIN and DONE.
- `start` is ignored outside IDLE. `base_addr`/`num_vectors` changes after sampling have no effect.
- Returned words are captured into a lane stage.
  - Lane 0: 1 register.
  - Lane i: 1+i registers.
  - Invalid slots carry 0x00, never stale data.
- `active` is aligned with lane 0 data only. The array propagates activity to later rows itself.
- `reset` asserted mid-batch: next cycle is IDLE, all outputs 0, delay lines flushed. No `done` pulse is issued.

## Timing
- `start` is sampled at the edge ending cycle 0. Reads are in cycles 1..N; `rd_data` is valid in cycles 2..N+1.
- Lane i carries vector k (0-based) in cycle 3+k+i. Latency from `start` to lane 0 data is 3 cycles.
- `active` = 1 in cycles 3..N+2 exactly. It is 0 in every other cycle.
- The last byte (lane W-1, vector N-1) appears in cycle N+W+1. `done` = 1 in cycle N+W+2. `busy` = 1 in cycles 1..N+W+2.
- The next `start` is accepted in cycle N+W+3. Back-to-back batches therefore have a gap of at least 1 cycle with `active`=0.
- `num_vectors`=0: `done`=1 and `busy`=1 in cycle 1 only. `rd_en`, `active` and `datain` stay 0.

## Structure
- Shared package `sys_arr_pkg` holds:
  - byte width constant (8),
  - read latency constant (1),
  - FSM state enum (IDLE, FETCH, DRAIN, DONE).
- Sub-module `lane_delay`, parameters depth and width=8: zero-initialised shift register with synchronous `reset`. The feeder generates width_height instances of it, with depth = 1+i.
- The top level holds the FSM, the address and vector counters, and the drain counter (range 0..width_height).

## Test plan
- W=2, base=0x00, N=3, buffer[0..2] = 0x0201, 0x0403, 0x0605:
  - `rd_addr` 0,1,2 in cycles 1-3.
  - `datain` = 0x0001, 0x0203, 0x0405, 0x0600 in cycles 3-6.
  - `active` high in cycles 3-5.
  - `done` in cycle 7.
- W=4, base=0xFE, N=4: `rd_addr` = 0xFE, 0xFF, 0x00, 0x01 (wrap). Lane 3 shows vector 0 in cycle 6. `done` in cycle 10.
- N=0: `done` and `busy` pulse in cycle 1. `rd_en` and `active` never assert.
- `start` re-asserted during FETCH and again during DRAIN: ignored. Exactly one `done`. Then a fresh `start` in the cycle after `done` is accepted.
- `reset` asserted in cycle N+1 of a W=4, N=5 batch:
  - next cycle: all outputs 0, state IDLE, no `done`.
  - a following batch produces no leftover non-zero bytes.
- W=2, N=1 followed immediately by N=2: `active` pattern is 1,0,…,1,1 with a 0x00 gap in lane 0. Lane values match the buffer contents byte-for-byte.
